// File: rtl/timer_cfg_pkg.sv
// Shared types and constants for the timer configuration arbiter:
// FSM states, timer register map and control-register bit positions.
package timer_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_STOP,
    S_P0,
    S_P1,
    S_P2,
    S_P3,
    S_START,
    S_SNAP,
    S_RD_LO,
    S_RD_HI,
    S_RD_CAP,
    S_DONE
  } state_t;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;
  localparam logic [3:0] ADDR_SNAP2   = 4'd8;
  localparam logic [3:0] ADDR_SNAP3   = 4'd9;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  localparam logic OP_PROGRAM  = 1'b0;
  localparam logic OP_SNAPSHOT = 1'b1;

  function automatic logic [15:0] ctrl_word(input logic start, input logic stop,
                                            input logic cont, input logic ito);
    logic [15:0] w;
    w             = '0;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    w[CTRL_CONT]  = cont;
    w[CTRL_ITO]   = ito;
    return w;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2 #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] grant
);

  // Pointer holds the last winner; start as if the other side won so RR_INIT takes the first tie.
  localparam logic LAST_INIT = (RR_INIT == 0);

  logic last_q;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_q <= LAST_INIT;
    else if (|grant)  last_q <= grant[1];
  end

endmodule

// File: rtl/timer_cfg_arbiter.sv
// Arbitrates two requesters onto a 16-bit timer register bus, running either a
// program sequence (stop, load period, start) or a snapshot read of the counter.
module timer_cfg_arbiter
  import timer_cfg_pkg::*;
#(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_period,
  input  logic [1:0]  req_cont,
  input  logic [1:0]  req_ito,
  output logic [1:0]  done,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [3:0]  tm_address,
  output logic        tm_chipselect,
  output logic        tm_write_n,
  output logic [15:0] tm_writedata,
  input  logic [15:0] tm_readdata
);

  state_t      state_q, state_d;
  logic [1:0]  grant;
  logic        accept;
  logic        gid_q, op_q, cont_q, ito_q;
  logic [31:0] period_q;

  // Grants are only offered in IDLE and never while reset is held.
  rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .enable ((state_q == S_IDLE) && !reset),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // NOTE: the request latch is a handful of control flops, so it is reset along with the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gid_q    <= 1'b0;
      op_q     <= OP_PROGRAM;
      cont_q   <= 1'b0;
      ito_q    <= 1'b0;
      period_q <= '0;
    end else if (accept) begin
      gid_q    <= grant[1];
      op_q     <= grant[1] ? req_op[1]          : req_op[0];
      cont_q   <= grant[1] ? req_cont[1]        : req_cont[0];
      ito_q    <= grant[1] ? req_ito[1]         : req_ito[0];
      period_q <= grant[1] ? req_period[63:32]  : req_period[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (op_of_grant() == OP_SNAPSHOT) ? S_SNAP : S_STOP;
      S_STOP:   state_d = S_P0;
      S_P0:     state_d = S_P1;
      S_P1:     state_d = S_P2;
      S_P2:     state_d = S_P3;
      S_P3:     state_d = S_START;
      S_START:  state_d = S_DONE;
      S_SNAP:   state_d = S_RD_LO;
      S_RD_LO:  state_d = S_RD_HI;
      S_RD_HI:  state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  function automatic logic op_of_grant();
    return grant[1] ? req_op[1] : req_op[0];
  endfunction

  // tm_readdata lags the address by one cycle: RD_HI sees SNAP0, RD_CAP sees SNAP1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    rsp_data         <= '0;
    else if (state_q == S_RD_HI)  rsp_data[15:0]   <= tm_readdata;
    else if (state_q == S_RD_CAP) rsp_data[31:16]  <= tm_readdata;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    tm_chipselect = 1'b0;
    tm_write_n    = 1'b1;
    tm_address    = ADDR_STATUS;
    tm_writedata  = 16'h0000;
    case (state_q)
      S_STOP:   begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_CONTROL;
                      tm_writedata = ctrl_word(1'b0, 1'b1, 1'b0, 1'b0); end
      S_P0:     begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_PERIOD0;
                      tm_writedata = period_q[15:0]; end
      S_P1:     begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_PERIOD1;
                      tm_writedata = period_q[31:16]; end
      S_P2:     begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_PERIOD2; end
      S_P3:     begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_PERIOD3; end
      S_START:  begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_CONTROL;
                      tm_writedata = ctrl_word(1'b1, 1'b0, cont_q, ito_q); end
      S_SNAP:   begin tm_chipselect = 1'b1; tm_write_n = 1'b0; tm_address = ADDR_SNAP0; end
      S_RD_LO:  begin tm_chipselect = 1'b1; tm_address = ADDR_SNAP0; end
      S_RD_HI:  begin tm_chipselect = 1'b1; tm_address = ADDR_SNAP1; end
      S_RD_CAP: begin tm_chipselect = 1'b1; tm_address = ADDR_SNAP1; end
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_timer_cfg_arbiter.sv
// Self-checking bench for timer_cfg_arbiter: directed scenarios plus randomized
// operations compared against a transaction-level model of the expected bus traffic.
module tb_timer_cfg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_op, req_cont, req_ito, done;
  logic [63:0] req_period;
  logic [31:0] rsp_data;
  logic        busy;
  logic [3:0]  tm_address;
  logic        tm_chipselect, tm_write_n;
  logic [15:0] tm_writedata;
  logic [15:0] tm_readdata = 16'h0;

  timer_cfg_arbiter #(.RR_INIT(0)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_period    (req_period),
    .req_cont      (req_cont),
    .req_ito       (req_ito),
    .done          (done),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .tm_address    (tm_address),
    .tm_chipselect (tm_chipselect),
    .tm_write_n    (tm_write_n),
    .tm_writedata  (tm_writedata),
    .tm_readdata   (tm_readdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Timer model: a write to SNAP0 freezes the counter; reads come back one cycle later.
  logic [31:0] snap_src = 32'h0;
  logic [31:0] snap_reg = 32'h0;
  always @(posedge clk) begin
    if (tm_chipselect && !tm_write_n && tm_address == 4'd6) snap_reg <= snap_src;
    if (tm_chipselect && tm_write_n)
      tm_readdata <= (tm_address == 4'd6) ? snap_reg[15:0] :
                     (tm_address == 4'd7) ? snap_reg[31:16] : 16'h0;
  end

  // Bus events are packed as {is_write, address, write data}.
  typedef logic [20:0] evt_t;
  evt_t bus_q[$];
  evt_t exp_q[$];
  int   gnt_q[$];
  int   ready_cnt[2] = '{0, 0};
  int   done_cnt[2]  = '{0, 0};

  always @(negedge clk) begin
    if (tm_chipselect)
      bus_q.push_back({~tm_write_n, tm_address, tm_write_n ? 16'h0 : tm_writedata});
    else
      check("idle bus", {11'h0, tm_write_n, tm_address, tm_writedata}, {11'h0, 1'b1, 4'h0, 16'h0});
    for (int g = 0; g < 2; g++) begin
      if (req_ready[g]) begin ready_cnt[g]++; gnt_q.push_back(g); end
      if (done[g]) done_cnt[g]++;
    end
  end

  bit          last_model;
  logic [31:0] exp_rsp;

  task automatic build_exp(input logic op, input logic [31:0] p, input logic cont, input logic ito);
    exp_q.delete();
    if (op == 1'b0) begin
      exp_q.push_back({1'b1, 4'd1, 16'h0008});
      exp_q.push_back({1'b1, 4'd2, p[15:0]});
      exp_q.push_back({1'b1, 4'd3, p[31:16]});
      exp_q.push_back({1'b1, 4'd4, 16'h0000});
      exp_q.push_back({1'b1, 4'd5, 16'h0000});
      exp_q.push_back({1'b1, 4'd1, 16'h0004 + (cont ? 16'd2 : 16'd0) + (ito ? 16'd1 : 16'd0)});
    end else begin
      exp_q.push_back({1'b1, 4'd6, 16'h0000});
      exp_q.push_back({1'b0, 4'd6, 16'h0000});
      exp_q.push_back({1'b0, 4'd7, 16'h0000});
      exp_q.push_back({1'b0, 4'd7, 16'h0000});
    end
  endtask

  task automatic compare_bus();
    check("bus count", bus_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bus_q.size(); i++)
      check($sformatf("bus evt %0d", i), {11'h0, bus_q[i]}, {11'h0, exp_q[i]});
  endtask

  task automatic do_op(input int g, input logic op, input logic [31:0] p, input logic cont,
                       input logic ito, input logic [31:0] snap, input bit glitch);
    int other, rc_other, dc, acc_c, done_c;
    bit got;
    other = 1 - g;
    snap_src = snap;
    build_exp(op, p, cont, ito);
    @(posedge clk); #1;
    bus_q.delete();
    req_op[g] = op; req_period[32*g +: 32] = p; req_cont[g] = cont; req_ito[g] = ito;
    req_valid[g] = 1'b1;
    rc_other = ready_cnt[other];
    dc = done_cnt[g];
    acc_c = 0; done_c = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req_ready[g]) begin got = 1; acc_c = cyc; end
    end
    check("accept seen", {31'h0, got}, 32'd1);
    if (!got) begin req_valid[g] = 1'b0; return; end
    last_model = (g == 1);
    // Scramble the inputs after accept; the operation in flight must not notice.
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    req_op[g] = 1'($urandom); req_period[32*g +: 32] = $urandom;
    req_cont[g] = 1'($urandom); req_ito[g] = 1'($urandom);
    if (glitch) begin
      req_op[other] = 1'($urandom); req_valid[other] = 1'b1;
      @(posedge clk); #1;
      req_valid[other] = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done[g]) begin got = 1; done_c = cyc; end
    end
    check("done seen", {31'h0, got}, 32'd1);
    check("latency", done_c - acc_c, op ? 32'd5 : 32'd7);
    if (op) exp_rsp = snap;
    check("rsp_data", rsp_data, exp_rsp);
    @(negedge clk);
    check("done width", {30'h0, done}, 32'd0);
    check("done count", done_cnt[g] - dc, 32'd1);
    compare_bus();
    if (glitch) check("glitch no accept", ready_cnt[other] - rc_other, 32'd0);
    repeat (3) @(negedge clk);
    check("post-op quiet", bus_q.size(), exp_q.size());
  endtask

  task automatic model_reset();
    last_model = 1'b1;
    exp_rsp    = 32'h0;
  endtask

  task automatic tie_test();
    int w_exp, winner, dl;
    logic [31:0] p0, p1;
    bit got;
    w_exp = last_model ? 0 : 1;
    p0 = $urandom; p1 = $urandom;
    build_exp(1'b0, (w_exp == 1) ? p1 : p0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus_q.delete();
    req_op = 2'b00; req_cont = 2'b00; req_ito = 2'b11;
    req_period = {p1, p0};
    dl = done_cnt[1 - w_exp];
    req_valid = 2'b11;
    got = 0; winner = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (|req_ready) begin got = 1; winner = req_ready[1] ? 1 : 0; end
    end
    check("tie accept seen", {31'h0, got}, 32'd1);
    check("tie winner", winner, w_exp);
    last_model = (winner == 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (12) @(negedge clk);
    check("tie loser no done", done_cnt[1 - w_exp] - dl, 32'd0);
    compare_bus();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int d0, d1;
    bit got;
    reset = 1'b1;
    req_valid = 2'b11; req_op = 2'b00; req_cont = 2'b00; req_ito = 2'b00;
    req_period = {32'h0000_2222, 32'h0000_1111};
    model_reset();
    repeat (3) @(negedge clk);
    check("reset req_ready", {30'h0, req_ready}, 32'd0);
    check("reset done", {30'h0, done}, 32'd0);
    check("reset busy", {31'h0, busy}, 32'd0);
    check("reset rsp_data", rsp_data, 32'h0);
    check("reset chipselect", {31'h0, tm_chipselect}, 32'd0);
    check("reset write_n", {31'h0, tm_write_n}, 32'd1);

    // Both requesters held valid from reset: grants must alternate starting at RR_INIT.
    gnt_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 120 && gnt_q.size() < 4; i++) @(negedge clk);
    req_valid = 2'b00;
    check("rr accept count", gnt_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
      w = last_model ? 0 : 1;
      last_model = (w == 1);
      check($sformatf("rr grant %0d", i), gnt_q[i], w);
    end
    repeat (12) @(negedge clk);
    check("rr done req0", done_cnt[0], 32'd2);
    check("rr done req1", done_cnt[1], 32'd2);

    do_op(0, 1'b0, 32'h0001_86A0, 1'b1, 1'b1, 32'h0, 1'b0);
    do_op(1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 1'b0);
    do_op(0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
    do_op(1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    do_op(0, 1'b0, $urandom, 1'b0, 1'b1, 32'h0, 1'b1);
    do_op(1, 1'b1, 32'h0, 1'b0, 1'b0, 32'hA5A5_0F0F, 1'b1);

    for (int k = 0; k < 10; k++)
      do_op(int'($urandom_range(0, 1)), 1'($urandom), $urandom, 1'($urandom),
            1'($urandom), $urandom, 1'($urandom));
    tie_test();
    tie_test();

    // Reset in the middle of P1 must idle the bus at once and cancel the operation.
    @(posedge clk); #1;
    req_op[0] = 1'b0; req_period[31:0] = 32'hCAFE_BABE; req_valid[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = req_ready[0];
    end
    check("abort accept seen", {31'h0, got}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort in P1 addr", {28'h0, tm_address}, 32'd3);
    check("abort in P1 data", {16'h0, tm_writedata}, 32'h0000_CAFE);
    d0 = done_cnt[0]; d1 = done_cnt[1];
    #1 reset = 1'b1;
    #1;
    check("abort chipselect", {31'h0, tm_chipselect}, 32'd0);
    check("abort address", {28'h0, tm_address}, 32'd0);
    check("abort busy", {31'h0, busy}, 32'd0);
    check("abort rsp_data", rsp_data, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort no done", (done_cnt[0] - d0) + (done_cnt[1] - d1), 32'd0);
    do_op(0, 1'b0, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h0, 1'b0);
    tie_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_cfg_arbiter.md
TIMER_CFG_ARBITER -- requirements
Module: timer_cfg_arbiter

Interface
REQ-001 The block SHALL have one parameter: RR_INIT, default 0, the requester that wins the first simultaneous request after reset.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request; held until accepted.
- req_ready  out  2  per-requester accept strobe, one cycle.
- req_op  in  2  per-requester operation: 0 = program, 1 = snapshot.
- req_period  in  64  per-requester 32-bit period; requester i uses bits [32i+31:32i].
- req_cont  in  2  per-requester continuous-mode bit.
- req_ito  in  2  per-requester interrupt-enable bit.
- done  out  2  per-requester completion strobe, one cycle.
- rsp_data  out  32  snapshot value; valid while done is asserted.
- busy  out  1  high in every state except IDLE.
- tm_address  out  4  timer register address.
- tm_chipselect  out  1  timer select.
- tm_write_n  out  1  timer write strobe, active low.
- tm_writedata  out  16  timer write data.
- tm_readdata  in  16  timer read data; registered, so it reflects the previous cycle's tm_address.

Function
REQ-003 The block SHALL accept requests only in IDLE. req_ready[g] SHALL be asserted combinationally in the same cycle that grant g is chosen. In that cycle the block SHALL latch req_op, the period, cont and ito for requester g.
REQ-004 Arbitration SHALL be round-robin. If exactly one requester is valid, it wins. If both are valid, the requester not granted last wins. The last-granted pointer SHALL update on every accept.
REQ-005 The program sequence SHALL be IDLE -> STOP -> P0 -> P1 -> P2 -> P3 -> START -> DONE -> IDLE, with one cycle per state and one bus write per state.
- STOP: address 1, data 0x0008.
- P0: address 2, data period[15:0].
- P1: address 3, data period[31:16].
- P2: address 4, data 0x0000.
- P3: address 5, data 0x0000.
- START: address 1, data 0x0004 | cont<<1 | ito.
REQ-006 The snapshot sequence SHALL be IDLE -> SNAP -> RD_LO -> RD_HI -> RD_CAP -> DONE -> IDLE.
- SNAP: write address 6, data 0.
- RD_LO: read address 6.
- RD_HI: read address 7; capture tm_readdata into rsp_data[15:0].
- RD_CAP: hold address 7; capture tm_readdata into rsp_data[31:16].
REQ-007 In DONE the block SHALL pulse done[g] for exactly one cycle. rsp_data SHALL be valid in that cycle and hold its value until the next snapshot capture. For a program operation, rsp_data SHALL be left unchanged.
REQ-008 Bus signalling rules:
- Write state: tm_chipselect = 1, tm_write_n = 0.
- Read state: tm_chipselect = 1, tm_write_n = 1.
- IDLE and DONE: tm_chipselect = 0, tm_write_n = 1, tm_address = 0, tm_writedata = 0.
REQ-009 Latency from accept to done SHALL be 7 cycles for program and 5 cycles for snapshot.
REQ-010 A new request SHALL NOT be accepted in DONE. The earliest re-accept is the IDLE cycle that follows DONE.
REQ-011 A req_valid that drops before it is accepted SHALL have no effect. Changes to request inputs after accept SHALL NOT affect the operation in flight.
REQ-012 A period of 0 SHALL be written as-is. A period of 0xFFFFFFFF SHALL be written as P0 = 0xFFFF and P1 = 0xFFFF.

Reset
REQ-013 Asserting reset at any time, including mid-sequence, SHALL immediately force:
- state = IDLE;
- req_ready = 0, done = 0, busy = 0;
- rsp_data = 0;
- tm_chipselect = 0, tm_write_n = 1, tm_address = 0, tm_writedata = 0;
- last-granted pointer set so that RR_INIT wins the next tie.
REQ-014 An operation interrupted by reset SHALL NOT resume, and SHALL NOT produce done.

Structure
REQ-015 A shared package timer_cfg_pkg SHALL hold:
- the state enumeration;
- timer register address constants (STATUS = 0, CONTROL = 1, PERIOD0..3 = 2..5, SNAP0..3 = 6..9);
- control bit positions (ITO = 0, CONT = 1, START = 2, STOP = 3).
REQ-016 The round-robin grant logic SHALL be one sub-module, rr_arb2. The FSM, request latch and bus drive SHALL remain in timer_cfg_arbiter.

Verification
REQ-017 Requester 0 programs period 0x0001_86A0 with cont = 1, ito = 1 -> bus writes (1,0x0008), (2,0x86A0), (3,0x0001), (4,0), (5,0), (1,0x0007); done[0] pulses 7 cycles after accept.
REQ-018 Snapshot request with a timer model whose snapshot is 0x1234_5678 -> write (6,0), reads of addresses 6 and 7; done[1] pulses with rsp_data = 0x12345678.
REQ-019 Both requesters valid from reset with RR_INIT = 0 -> requester 0 is granted, then requester 1, then requester 0, alternating; no request is dropped.
REQ-020 Reset asserted during P1 -> bus idles in the same cycle, no done pulse; a fresh request after reset runs the full sequence from STOP.
REQ-021 Requester raises req_valid for one cycle while busy, then drops it -> no accept and no bus activity for that request.
REQ-022 Program with period 0xFFFF_FFFF, cont = 0, ito = 0 -> P0 and P1 both write 0xFFFF; START writes 0x0004.
